sync_sdp_ram: RTL and testbench
===============================

Name: sync_sdp_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, single clock.
- Depth is 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Used by the memory walkers as the per-loop stride buffer and the per-loop offset buffer. Each has one write per cycle and one read per cycle, indexed by loop id.
- Read data is registered (1-cycle latency) and is held between reads.

Parameters:
- ADDR_WIDTH, default 5, word address width; depth = 2^ADDR_WIDTH.
- DATA_WIDTH, default 16, word width in bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- s_write_addr  in  ADDR_WIDTH  write word address.
- s_write_req  in  1  write enable.
- s_write_data  in  DATA_WIDTH  write data.
- s_read_addr  in  ADDR_WIDTH  read word address.
- s_read_req  in  1  read enable.
- s_read_data  out  DATA_WIDTH  registered read data.

Behaviour:
- Storage: array mem[0 .. 2^ADDR_WIDTH-1] of DATA_WIDTH bits. No address checking; every address is valid, with no wrap logic.
- Reset: on a rising edge with reset==0, s_read_data <= 0.
  - Writes and reads are ignored that cycle.
  - Array contents are untouched unless RAM_RESET_CLEAR_EN is defined.
- Write: on a rising edge with reset==1 and s_write_req==1, mem[s_write_addr] <= s_write_data. The new value is visible to reads issued on the following cycle or later.
- Read: on a rising edge with reset==1 and s_read_req==1, s_read_data <= mem[s_read_addr].
  - Latency is exactly 1 cycle: data for a request in cycle N is valid from after edge N through cycle N+1.
  - It holds until the next read or reset.
- No read request: s_read_data holds its last value (no clear, no X).
- Simultaneous read and write, same address: read-first. s_read_data gets the old contents; the array gets the new data. No write-to-read forwarding.
- Simultaneous read and write, different addresses: both proceed independently.
- Back-to-back reads: one read per cycle, full throughput, no stall.
- Back-to-back writes: one write per cycle, full throughput, no stall.
- Reset asserted mid-operation: any in-flight read result is replaced by 0. Writes presented during reset are dropped.
- No handshake or ready signal. Requests are always accepted.
- Write data is stored bit-exact; no arithmetic.

Optional Feature:
- Macro RAM_RESET_CLEAR_EN.
- Defined: every rising edge with reset==0 also sets every mem word to 0. A read of any unwritten address after reset returns 0.
- Not defined: the array has no reset. Contents after power-up are undefined (X in simulation) until written. Only s_read_data is reset.

Test Plan (ADDR_WIDTH=5, DATA_WIDTH=16):
- Reset: hold reset=0 for 2 cycles, then reset=1 -> s_read_data==0x0000; stays 0 while s_read_req=0.
- Write then read: write addr 3 = 0x1234; next cycle read addr 3 -> s_read_data==0x1234 one cycle after the request; holds 0x1234 for 5 idle cycles.
- Read-during-write: mem[7]=0xAAAA, then in the same cycle write addr 7 = 0x5555 and read addr 7 -> read returns 0xAAAA; a read the next cycle returns 0x5555.
- Streaming: write addrs 0..31 with data 0x100+addr on consecutive cycles, then read 31..0 consecutively -> each returns 0x100+addr with 1-cycle latency, no bubbles.
- Reset mid-stream: issue read of addr 5 (0x0105) in the same cycle reset=0 -> s_read_data==0; after reset, read addr 5 -> 0x0105 without the macro; 0x0000 with RAM_RESET_CLEAR_EN.
- Independent ports: write addr 10 = 0xBEEF while reading addr 11 = 0xCAFE -> read returns 0xCAFE; a subsequent read of addr 10 returns 0xBEEF.

Source files
------------

// File: rtl/sync_sdp_ram_if.sv
// Port bundle for sync_sdp_ram: one write channel and one read channel.
// The master drives requests; the slave (the RAM) returns registered read data.
interface sync_sdp_ram_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] s_write_addr;
  logic                  s_write_req;
  logic [DATA_WIDTH-1:0] s_write_data;
  logic [ADDR_WIDTH-1:0] s_read_addr;
  logic                  s_read_req;
  logic [DATA_WIDTH-1:0] s_read_data;

  modport master (
    output s_write_addr,
    output s_write_req,
    output s_write_data,
    output s_read_addr,
    output s_read_req,
    input  s_read_data
  );

  modport slave (
    input  s_write_addr,
    input  s_write_req,
    input  s_write_data,
    input  s_read_addr,
    input  s_read_req,
    output s_read_data
  );
endinterface

// File: rtl/sync_sdp_ram.sv
// Simple dual-port RAM: one write and one read per cycle, read-first, 1-cycle registered read.
// Define RAM_RESET_CLEAR_EN to also clear the whole array while reset is held low.
module sync_sdp_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  sync_sdp_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_read_data;

  // Read samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_read_data <= '0;
    end else if (bus.s_read_req) begin
      r_read_data <= r_mem[bus.s_read_addr];
    end
  end

`ifdef RAM_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.s_write_req) begin
      r_mem[bus.s_write_addr] <= bus.s_write_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset && bus.s_write_req) begin
      r_mem[bus.s_write_addr] <= bus.s_write_data;
    end
  end
`endif

  assign bus.s_read_data = r_read_data;
endmodule

// File: tb/tb_sync_sdp_ram.sv
// Directed self-checking bench for sync_sdp_ram (ADDR_WIDTH=5, DATA_WIDTH=16).
module tb_sync_sdp_ram;
  localparam int AW = 5;
  localparam int DW = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  sync_sdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  sync_sdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.s_write_req  = 1'b0;
    bus_if.s_write_addr = '0;
    bus_if.s_write_data = '0;
    bus_if.s_read_req   = 1'b0;
    bus_if.s_read_addr  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    reset = 1'b1;
    n_checks++;
    if (bus_if.s_read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_value: got %h expected %h", bus_if.s_read_data, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (bus_if.s_read_data !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, bus_if.s_read_data, 16'h0000);
      end
    end
  endtask

  task automatic test_write_read();
    bus_if.s_write_req  = 1'b1;
    bus_if.s_write_addr = 5'd3;
    bus_if.s_write_data = 16'h1234;
    cycle();
    bus_if.s_write_req  = 1'b0;
    bus_if.s_read_req   = 1'b1;
    bus_if.s_read_addr  = 5'd3;
    cycle();
    bus_if.s_read_req   = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_read: got %h expected %h", bus_if.s_read_data, 16'h1234);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (bus_if.s_read_data !== 16'h1234) begin
        n_fail++;
        $display("FAIL read_hold[%0d]: got %h expected %h", i, bus_if.s_read_data, 16'h1234);
      end
    end
  endtask

  task automatic test_read_during_write();
    bus_if.s_write_req  = 1'b1;
    bus_if.s_write_addr = 5'd7;
    bus_if.s_write_data = 16'hAAAA;
    cycle();
    bus_if.s_write_data = 16'h5555;
    bus_if.s_read_req   = 1'b1;
    bus_if.s_read_addr  = 5'd7;
    cycle();
    bus_if.s_write_req  = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL rdw_old_data: got %h expected %h", bus_if.s_read_data, 16'hAAAA);
    end
    cycle();
    bus_if.s_read_req = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'h5555) begin
      n_fail++;
      $display("FAIL rdw_new_data: got %h expected %h", bus_if.s_read_data, 16'h5555);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    for (int a = 0; a < 32; a++) begin
      bus_if.s_write_req  = 1'b1;
      bus_if.s_write_addr = AW'(a);
      bus_if.s_write_data = DW'(16'h0100 + a);
      cycle();
    end
    bus_if.s_write_req = 1'b0;
    for (int a = 31; a >= 0; a--) begin
      bus_if.s_read_req  = 1'b1;
      bus_if.s_read_addr = AW'(a);
      cycle();
      exp = DW'(16'h0100 + a);
      n_checks++;
      if (bus_if.s_read_data !== exp) begin
        n_fail++;
        $display("FAIL stream_read[%0d]: got %h expected %h", a, bus_if.s_read_data, exp);
      end
    end
    bus_if.s_read_req = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    logic [DW-1:0] exp5;
    logic [DW-1:0] exp20;
`ifdef RAM_RESET_CLEAR_EN
    exp5  = 16'h0000;
    exp20 = 16'h0000;
`else
    exp5  = 16'h0105;
    exp20 = 16'h0114;
`endif
    // Output currently holds 0x0100 from the last stream read, so a clear is observable.
    reset               = 1'b0;
    bus_if.s_read_req   = 1'b1;
    bus_if.s_read_addr  = 5'd5;
    bus_if.s_write_req  = 1'b1;
    bus_if.s_write_addr = 5'd20;
    bus_if.s_write_data = 16'hDEAD;
    cycle();
    reset              = 1'b1;
    bus_if.s_write_req = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_read: got %h expected %h", bus_if.s_read_data, 16'h0000);
    end
    cycle();
    n_checks++;
    if (bus_if.s_read_data !== exp5) begin
      n_fail++;
      $display("FAIL post_reset_read5: got %h expected %h", bus_if.s_read_data, exp5);
    end
    bus_if.s_read_addr = 5'd20;
    cycle();
    bus_if.s_read_req = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== exp20) begin
      n_fail++;
      $display("FAIL reset_write_dropped: got %h expected %h", bus_if.s_read_data, exp20);
    end
  endtask

  task automatic test_independent_ports();
    bus_if.s_write_req  = 1'b1;
    bus_if.s_write_addr = 5'd11;
    bus_if.s_write_data = 16'hCAFE;
    cycle();
    bus_if.s_write_addr = 5'd10;
    bus_if.s_write_data = 16'hBEEF;
    bus_if.s_read_req   = 1'b1;
    bus_if.s_read_addr  = 5'd11;
    cycle();
    bus_if.s_write_req = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'hCAFE) begin
      n_fail++;
      $display("FAIL indep_read11: got %h expected %h", bus_if.s_read_data, 16'hCAFE);
    end
    bus_if.s_read_addr = 5'd10;
    cycle();
    bus_if.s_read_req = 1'b0;
    n_checks++;
    if (bus_if.s_read_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL indep_read10: got %h expected %h", bus_if.s_read_data, 16'hBEEF);
    end
    cycle();
    n_checks++;
    if (bus_if.s_read_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL indep_hold: got %h expected %h", bus_if.s_read_data, 16'hBEEF);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid_stream();
    test_independent_ports();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
